// File: rtl/tmul_tile_loader_if.sv
// Stream and tile handshake bundle between a word producer, the tile loader
// and the tile multiplier's operand inputs.
interface tmul_tile_loader_if #(
   parameter int N = 8,
   parameter int W = 32
);
   logic [W-1:0]   in_data;
   logic           in_valid;
   logic           in_last;
   logic           in_ready;
   logic [W-1:0]   a_out [N-1:0];
   logic [N*W-1:0] b_out [N-1:0];
   logic           tile_valid;
   logic           tile_ready;

   modport master (
      output in_data, in_valid, in_last, tile_ready,
      input  in_ready, a_out, b_out, tile_valid
   );

   modport slave (
      input  in_data, in_valid, in_last, tile_ready,
      output in_ready, a_out, b_out, tile_valid
   );
endinterface

// File: rtl/tmul_tile_loader.sv
// Assembles one 8x8 operand tile (8 a words + 64 b words) from a word stream
// and holds it on the multiplier inputs until the result is acknowledged.
module tmul_tile_loader #(
   parameter int N = 8,
   parameter int W = 32
) (
   input  logic                clk,
   input  logic                rst,
   tmul_tile_loader_if.slave   tif,
   output logic [15:0]         tile_count,
   output logic                err
);

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      FULL  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t         state_r;
   state_t         state_s;
   logic [6:0]     idx_r;
   logic [6:0]     idx_s;
   logic           err_r;
   logic           err_s;
   logic [15:0]    count_r;
   logic           wr_s;
   logic           inc_s;
   logic           acc_s;
   logic           in_ready_s;
   logic [2:0]     row_s;
   logic [2:0]     col_s;
   logic [W-1:0]   a_r [N-1:0];
   logic [N*W-1:0] b_r [N-1:0];

   // Handshake outputs decoded from registered state only; reset blocks intake.
   always_comb begin
      in_ready_s = rst & (state_r != FULL);
      acc_s      = tif.in_valid & in_ready_s;
   end

   // Word index to b row/column: indices 8..71 are row-major, so the row is
   // idx[6:3]-1 and the column is idx[2:0].
   always_comb begin
      row_s = 3'(idx_r[6:3] - 4'd1);
      col_s = idx_r[2:0];
   end

   // Next-state, index, error and write/handoff strobes.
   always_comb begin
      state_s = state_r;
      idx_s   = idx_r;
      err_s   = err_r;
      wr_s    = 1'b0;
      inc_s   = 1'b0;
      case (state_r)
         LOAD: begin
            if (acc_s) begin
               wr_s = 1'b1;
               if (idx_r == 7'd71) begin
                  idx_s = 7'd0;
                  if (tif.in_last) begin
                     state_s = FULL;
                  end else begin
                     err_s   = 1'b1;
                     state_s = DRAIN;
                  end
               end else if (tif.in_last) begin
                  // Early end marker: tile abandoned, restart at word 0.
                  err_s = 1'b1;
                  idx_s = 7'd0;
               end else begin
                  idx_s = idx_r + 7'd1;
               end
            end else begin
               idx_s = idx_r;
            end
         end
         FULL: begin
            if (tif.tile_ready) begin
               state_s = LOAD;
               inc_s   = 1'b1;
            end else begin
               state_s = FULL;
            end
         end
         DRAIN: begin
            if (acc_s && tif.in_last) begin
               state_s = LOAD;
               idx_s   = 7'd0;
            end else begin
               state_s = DRAIN;
            end
         end
         default: begin
            state_s = LOAD;
            idx_s   = 7'd0;
         end
      endcase
   end

   // State, counters and operand storage; operands are overwritten in place.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r <= LOAD;
         idx_r   <= 7'd0;
         err_r   <= 1'b0;
         count_r <= 16'd0;
         for (int i = 0; i < N; i++) begin
            a_r[i] <= '0;
            b_r[i] <= '0;
         end
      end else begin
         state_r <= state_s;
         idx_r   <= idx_s;
         err_r   <= err_s;
         if (inc_s) begin
            count_r <= count_r + 16'd1;
         end
         if (wr_s) begin
            if (idx_r[6:3] == 4'd0) begin
               a_r[col_s] <= tif.in_data;
            end else begin
               b_r[row_s][{col_s, 5'd0} +: W] <= tif.in_data;
            end
         end
      end
   end

   assign tif.in_ready   = in_ready_s;
   assign tif.tile_valid = (state_r == FULL);
   assign tif.a_out      = a_r;
   assign tif.b_out      = b_r;
   assign tile_count     = count_r;
   assign err            = err_r;

endmodule

// File: tb/tb_tmul_tile_loader.sv
// Directed bench for tmul_tile_loader: stimulus pushes expected tiles into a
// queue, a monitor pops and compares whenever a tile is presented.
module tb_tmul_tile_loader;

   logic        clk;
   logic        rst;
   logic [15:0] tile_count;
   logic        err;

   tmul_tile_loader_if tif ();

   tmul_tile_loader dut (
      .clk        (clk),
      .rst        (rst),
      .tif        (tif.slave),
      .tile_count (tile_count),
      .err        (err)
   );

   typedef struct packed {
      logic [7:0][31:0]  a;
      logic [7:0][255:0] b;
   } tile_t;

   tile_t expq[$];
   tile_t cur;
   bit    cur_ok;
   bit    prev_tv;
   int    checks;
   int    errors;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   // Stream word i of tile 'seed'; seed 0 is the reference tile of the test plan.
   function automatic logic [31:0] wval(input int seed, input int i);
      if (seed == 0) begin
         if (i < 8) return 32'(i + 1);
         else       return 32'(((i - 8) % 8) + 1);
      end
      return {seed[15:0], i[15:0]};
   endfunction

   function automatic tile_t make_tile(input int seed);
      tile_t t;
      for (int j = 0; j < 8; j++) begin
         t.a[j] = wval(seed, j);
         for (int k = 0; k < 8; k++) t.b[j][k*32 +: 32] = wval(seed, 8 + 8*j + k);
      end
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, act, exp);
      end
   endtask

   // Monitor: pop on a new tile, then compare contents on every held cycle.
   initial begin
      cur_ok  = 1'b0;
      prev_tv = 1'b0;
      forever begin
         @(negedge clk);
         if (rst && tif.tile_valid) begin
            if (!prev_tv) begin
               if (expq.size() == 0) begin
                  checks++;
                  errors++;
                  cur_ok = 1'b0;
                  $display("FAIL unexpected_tile got tile_valid=1 want no tile");
               end else begin
                  cur    = expq.pop_front();
                  cur_ok = 1'b1;
               end
            end
            if (cur_ok) begin
               int bad;
               bad = -1;
               for (int j = 0; j < 8; j++) begin
                  if (tif.a_out[j] !== cur.a[j] && bad < 0) bad = j;
                  if (tif.b_out[j] !== cur.b[j] && bad < 0) bad = 8 + j;
               end
               checks++;
               if (bad >= 0) begin
                  errors++;
                  if (bad < 8)
                     $display("FAIL tile_a[%0d] got %0h want %0h", bad, tif.a_out[bad], cur.a[bad]);
                  else
                     $display("FAIL tile_b[%0d] got %0h want %0h", bad - 8, tif.b_out[bad-8], cur.b[bad-8]);
               end
            end
         end
         prev_tv = rst && tif.tile_valid;
      end
   end

   task automatic send_word(input logic [31:0] d, input logic last, input bit gaps);
      int n;
      if (gaps && $urandom_range(1, 0) == 1) begin
         @(negedge clk);
         tif.in_valid = 1'b0;
         tif.in_last  = 1'b0;
      end
      @(negedge clk);
      tif.in_valid = 1'b1;
      tif.in_data  = d;
      tif.in_last  = last;
      n = 0;
      while (!tif.in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("in_ready_timeout", 32'(tif.in_ready), 32'd1);
      @(posedge clk);
   endtask

   task automatic idle();
      @(negedge clk);
      tif.in_valid = 1'b0;
      tif.in_last  = 1'b0;
   endtask

   task automatic send_tile(input int seed, input int nwords, input int last_at, input bit gaps);
      for (int i = 0; i < nwords; i++) send_word(wval(seed, i), (i == last_at), gaps);
      idle();
   endtask

   task automatic handoff(input logic [15:0] exp_cnt);
      tif.tile_ready = 1'b1;
      @(negedge clk);
      tif.tile_ready = 1'b0;
      chk("handoff_tile_valid", 32'(tif.tile_valid), 32'd0);
      chk("handoff_in_ready", 32'(tif.in_ready), 32'd1);
      chk("handoff_tile_count", 32'(tile_count), 32'(exp_cnt));
   endtask

   task automatic do_reset();
      bit zero;
      @(negedge clk);
      rst          = 1'b0;
      tif.in_valid = 1'b0;
      tif.in_last  = 1'b0;
      tif.tile_ready = 1'b0;
      @(negedge clk);
      zero = 1'b1;
      for (int j = 0; j < 8; j++)
         if (tif.a_out[j] !== 32'd0 || tif.b_out[j] !== 256'd0) zero = 1'b0;
      chk("rst_outputs_zero", 32'(zero), 32'd1);
      chk("rst_tile_valid", 32'(tif.tile_valid), 32'd0);
      chk("rst_in_ready", 32'(tif.in_ready), 32'd0);
      chk("rst_tile_count", 32'(tile_count), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", 32'(tif.in_ready), 32'd1);
   endtask

   initial begin
      checks         = 0;
      errors         = 0;
      rst            = 1'b0;
      tif.in_valid   = 1'b0;
      tif.in_last    = 1'b0;
      tif.in_data    = 32'd0;
      tif.tile_ready = 1'b0;
      do_reset();

      // Back-to-back reference tile with tile_ready held high.
      tif.tile_ready = 1'b1;
      expq.push_back(make_tile(0));
      send_tile(0, 72, 71, 1'b0);
      chk("b2b_tile_valid", 32'(tif.tile_valid), 32'd1);
      chk("b2b_in_ready", 32'(tif.in_ready), 32'd0);
      @(negedge clk);
      tif.tile_ready = 1'b0;
      chk("b2b_valid_one_cycle", 32'(tif.tile_valid), 32'd0);
      chk("b2b_in_ready_back", 32'(tif.in_ready), 32'd1);
      chk("b2b_tile_count", 32'(tile_count), 32'd1);
      chk("b2b_a3", tif.a_out[3], 32'd4);
      chk("b2b_b5_k6", tif.b_out[5][6*32 +: 32], 32'd7);

      // Backpressure: 20 stalled FULL cycles.
      expq.push_back(make_tile(2));
      send_tile(2, 72, 71, 1'b0);
      for (int c = 0; c < 20; c++) begin
         chk("bp_in_ready", 32'(tif.in_ready), 32'd0);
         chk("bp_tile_valid", 32'(tif.tile_valid), 32'd1);
         @(negedge clk);
      end
      handoff(16'd2);

      // Early last on word 40.
      do_reset();
      send_tile(9, 41, 40, 1'b0);
      chk("early_err", 32'(err), 32'd1);
      repeat (3) @(negedge clk);
      chk("early_no_tile", 32'(tif.tile_valid), 32'd0);
      expq.push_back(make_tile(3));
      send_tile(3, 72, 71, 1'b0);
      chk("early_next_valid", 32'(tif.tile_valid), 32'd1);
      handoff(16'd1);

      // Missing last on word 71, then drain 5 junk words.
      do_reset();
      send_tile(10, 72, -1, 1'b0);
      chk("miss_err", 32'(err), 32'd1);
      chk("miss_no_tile", 32'(tif.tile_valid), 32'd0);
      chk("drain_in_ready", 32'(tif.in_ready), 32'd1);
      send_tile(11, 5, 4, 1'b0);
      chk("drain_no_tile", 32'(tif.tile_valid), 32'd0);
      expq.push_back(make_tile(4));
      send_tile(4, 72, 71, 1'b0);
      chk("miss_next_valid", 32'(tif.tile_valid), 32'd1);
      handoff(16'd1);

      // Reset at word 30, then reset in FULL, then a clean tile.
      for (int i = 0; i < 30; i++) send_word(wval(5, i), 1'b0, 1'b0);
      do_reset();
      expq.push_back(make_tile(6));
      send_tile(6, 72, 71, 1'b0);
      chk("full_before_rst", 32'(tif.tile_valid), 32'd1);
      do_reset();
      expq.push_back(make_tile(7));
      send_tile(7, 72, 71, 1'b0);
      handoff(16'd1);

      // Random valid gaps give the same reference contents.
      expq.push_back(make_tile(0));
      send_tile(0, 72, 71, 1'b1);
      chk("stall_tile_valid", 32'(tif.tile_valid), 32'd1);
      handoff(16'd2);

      // Counter wrap from 0xFFFF.
      expq.push_back(make_tile(12));
      send_tile(12, 72, 71, 1'b0);
      force dut.count_r = 16'hFFFF;
      @(negedge clk);
      release dut.count_r;
      @(negedge clk);
      chk("wrap_preset", 32'(tile_count), 32'h0000FFFF);
      handoff(16'd0);

      repeat (3) @(negedge clk);
      chk("queue_drained", 32'(expq.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
